// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window filter: FSM states, mode
// encodings, default image geometry and arithmetic constants.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_GAUSS = 1'b0;
    localparam logic MODE_SOBEL = 1'b1;

    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 32;

    localparam int GAUSS_ROUND = 8;
    localparam int GAUSS_SHIFT = 4;
    localparam int SAT_MAX     = 255;

    // Clamp a 12-bit magnitude to the 8-bit pixel range.
    function automatic logic [7:0] sat8(input logic [11:0] v);
        return (v > 12'(SAT_MAX)) ? 8'(SAT_MAX) : v[7:0];
    endfunction

endpackage

// File: rtl/conv3x3_datapath.sv
// Three-stage arithmetic pipeline: weighted partial sums, Gaussian total and
// signed gradients, then round/shift or abs+saturate. No frame awareness.
module conv3x3_datapath
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    input  logic        mode_i,
    input  logic [71:0] window_i,
    output logic        s1_valid_o,
    output logic        s2_valid_o,
    output logic        wr_o,
    output logic [7:0]  pixel_o
);

    logic [9:0] row_d [3];
    logic [9:0] col_d [2];
    logic [9:0] row_q [3];
    logic [9:0] col_q [2];
    logic       v1_q;

    // Row sums feed both the Gaussian total and Gy; only the outer columns are needed for Gx.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            assign row_d[gi] = 10'(window_i[24*gi +: 8])
                             + {1'b0, window_i[24*gi+8 +: 8], 1'b0}
                             + 10'(window_i[24*gi+16 +: 8]);
        end
        for (gi = 0; gi < 2; gi++) begin : g_col
            assign col_d[gi] = 10'(window_i[16*gi +: 8])
                             + {1'b0, window_i[16*gi+24 +: 8], 1'b0}
                             + 10'(window_i[16*gi+48 +: 8]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            for (int i = 0; i < 3; i++) row_q[i] <= '0;
            for (int i = 0; i < 2; i++) col_q[i] <= '0;
        end else begin
            v1_q <= in_valid_i;
            if (in_valid_i) begin
                for (int i = 0; i < 3; i++) row_q[i] <= row_d[i];
                for (int i = 0; i < 2; i++) col_q[i] <= col_d[i];
            end
        end
    end

    logic [11:0]        gsum_d, gsum_q;
    logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
    logic               v2_q;

    assign gsum_d = {2'b00, row_q[0]} + {1'b0, row_q[1], 1'b0} + {2'b00, row_q[2]};
    assign gx_d   = $signed({1'b0, col_q[1]}) - $signed({1'b0, col_q[0]});
    assign gy_d   = $signed({1'b0, row_q[2]}) - $signed({1'b0, row_q[0]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            gsum_q <= '0;
            gx_q   <= '0;
            gy_q   <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                gsum_q <= gsum_d;
                gx_q   <= gx_d;
                gy_q   <= gy_d;
            end
        end
    end

    logic [10:0] gx_abs_d, gy_abs_d;
    logic [11:0] mag_d;
    logic [7:0]  gauss_pix_d, sobel_pix_d, pix_d, pix_q;
    logic        v3_q;

    assign gx_abs_d    = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    assign gy_abs_d    = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    assign mag_d       = {1'b0, gx_abs_d} + {1'b0, gy_abs_d};
    assign sobel_pix_d = sat8(mag_d);
    // Max rounded total is 4088, so the shifted value always fits in 8 bits.
    assign gauss_pix_d = 8'((gsum_q + 12'(GAUSS_ROUND)) >> GAUSS_SHIFT);
    assign pix_d       = (mode_i == MODE_SOBEL) ? sobel_pix_d : gauss_pix_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3_q  <= 1'b0;
            pix_q <= '0;
        end else begin
            v3_q <= v2_q;
            if (v2_q) pix_q <= pix_d;
        end
    end

    assign s1_valid_o = v1_q;
    assign s2_valid_o = v2_q;
    assign wr_o       = v3_q;
    assign pixel_o    = pix_q;

endmodule

// File: rtl/conv3x3_filter.sv
// Frame controller around the 3x3 filter pipeline: accepts IMG_W*IMG_H windows
// per frame, drains the pipeline, then flags done.
module conv3x3_filter
    import conv_pkg::*;
#(
    parameter int IMG_W       = DEF_IMG_W,
    parameter int IMG_H       = DEF_IMG_H,
    parameter int FRAME_CNT_W = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    input  logic       in_valid,
    input  logic [7:0] pixelr1,
    input  logic [7:0] pixelr2,
    input  logic [7:0] pixelr3,
    input  logic [7:0] pixelr4,
    input  logic [7:0] pixelr5,
    input  logic [7:0] pixelr6,
    input  logic [7:0] pixelr7,
    input  logic [7:0] pixelr8,
    input  logic [7:0] pixelr9,
    output logic [7:0] pixelw,
    output logic       wr,
    output logic       busy,
    output logic       done
);

    localparam logic [FRAME_CNT_W-1:0] LAST_IDX = FRAME_CNT_W'(IMG_W * IMG_H - 1);

    state_t                 state_q;
    logic [FRAME_CNT_W-1:0] cnt_q;
    logic                   mode_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   accept;
    logic                   s1_valid, s2_valid;

    assign accept = in_valid && (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_GAUSS;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        mode_q  <= mode;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_IDX) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Once stages 1 and 2 are empty the final result is on wr this cycle.
                    if (!s1_valid && !s2_valid) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    conv3x3_datapath u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (accept),
        .mode_i     (mode_q),
        .window_i   ({pixelr9, pixelr8, pixelr7, pixelr6, pixelr5,
                      pixelr4, pixelr3, pixelr2, pixelr1}),
        .s1_valid_o (s1_valid),
        .s2_valid_o (s2_valid),
        .wr_o       (wr),
        .pixel_o    (pixelw)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Directed bench for conv3x3_filter: single windows in both modes, back-to-back
// streaming, ignored inputs, mid-frame reset and a full default-size frame.
module tb_conv3x3_filter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] px [9];
    logic [7:0] pixelw;
    logic       wr, busy, done;

    int total = 0;
    int bad   = 0;

    localparam int FRAME = 256 * 32;

    always #5 clk = ~clk;

    conv3x3_filter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode     (mode),
        .in_valid (in_valid),
        .pixelr1  (px[0]),
        .pixelr2  (px[1]),
        .pixelr3  (px[2]),
        .pixelr4  (px[3]),
        .pixelr5  (px[4]),
        .pixelr6  (px[5]),
        .pixelr7  (px[6]),
        .pixelr8  (px[7]),
        .pixelr9  (px[8]),
        .pixelw   (pixelw),
        .wr       (wr),
        .busy     (busy),
        .done     (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_win(input logic [7:0] a, b, c, d, e, f, g, h, i);
        px[0] = a; px[1] = b; px[2] = c;
        px[3] = d; px[4] = e; px[5] = f;
        px[6] = g; px[7] = h; px[8] = i;
    endtask

    task automatic set_flat(input logic [7:0] v);
        for (int k = 0; k < 9; k++) px[k] = v;
    endtask

    // Drives the current window for one cycle and records wr over the next four cycles.
    task automatic send_one(output logic [3:0] wr_seq, output logic [7:0] pix3,
                            output logic [7:0] pix4);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wr_seq[0] = wr;
        step();
        wr_seq[1] = wr;
        step();
        wr_seq[2] = wr;
        pix3 = pixelw;
        step();
        wr_seq[3] = wr;
        pix4 = pixelw;
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        total++;
        if ({wr, busy, done} !== 3'b000 || pixelw !== 8'd0) begin
            bad++;
            $display("FAIL reset_hold: wr/busy/done=%b pixelw=%0d, need 000 and 0",
                     {wr, busy, done}, pixelw);
        end
        rst_n = 1'b1;
        step();
        total++;
        if ({wr, busy, done} !== 3'b000 || pixelw !== 8'd0) begin
            bad++;
            $display("FAIL reset_release: wr/busy/done=%b pixelw=%0d, need 000 and 0",
                     {wr, busy, done}, pixelw);
        end
        $display("test_reset: checked");
    endtask

    task automatic test_idle_ignore();
        int wr_seen = 0;
        set_flat(8'd90);
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 4) in_valid = 1'b0;
            if (wr) wr_seen++;
        end
        total++;
        if (wr_seen !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_ignore: wr pulses=%0d busy=%b, need 0 and 0", wr_seen, busy);
        end
        $display("test_idle_ignore: wr pulses=%0d", wr_seen);
    endtask

    // start together with in_valid: that window must not be accepted.
    task automatic test_start_same_cycle();
        int wr_seen = 0;
        set_flat(8'd50);
        start    = 1'b1;
        mode     = 1'b0;
        in_valid = 1'b1;
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: busy=%b, need 1", busy);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            if (wr) wr_seen++;
        end
        total++;
        if (wr_seen !== 0) begin
            bad++;
            $display("FAIL start_same_cycle: wr pulses=%0d, need 0", wr_seen);
        end
        $display("test_start_same_cycle: wr pulses=%0d", wr_seen);
    endtask

    task automatic test_gauss();
        logic [71:0] wins [4];
        logic [7:0]  exp_pix [4];
        logic [3:0]  seq;
        logic [7:0]  p3, p4;
        wins[0] = {9{8'd100}};                                   exp_pix[0] = 8'd100;
        wins[1] = {32'd0, 8'd16, 32'd0};                         exp_pix[1] = 8'd4;
        wins[2] = {9{8'd255}};                                   exp_pix[2] = 8'd255;
        wins[3] = {64'd0, 8'd200};                               exp_pix[3] = 8'd13;
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < 9; k++) px[k] = wins[t][8*k +: 8];
            send_one(seq, p3, p4);
            total++;
            if (seq !== 4'b0100) begin
                bad++;
                $display("FAIL gauss_latency[%0d]: wr seq=%b, need 0100", t, seq);
            end
            total++;
            if (p3 !== exp_pix[t] || p4 !== exp_pix[t]) begin
                bad++;
                $display("FAIL gauss_value[%0d]: pixelw=%0d hold=%0d, need %0d",
                         t, p3, p4, exp_pix[t]);
            end
            $display("test_gauss[%0d]: wr seq=%b pixelw=%0d", t, seq, p3);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals [3];
        logic [6:0] wr_obs;
        logic [7:0] pix_obs [7];
        vals[0] = 8'd100; vals[1] = 8'd7; vals[2] = 8'd255;
        wr_obs[0] = wr;
        pix_obs[0] = pixelw;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                set_flat(vals[k]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            wr_obs[k+1]  = wr;
            pix_obs[k+1] = pixelw;
        end
        total++;
        if (wr_obs !== 7'b0111000) begin
            bad++;
            $display("FAIL b2b_wr: wr pattern=%b, need 0111000", wr_obs);
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (pix_obs[k+3] !== vals[k]) begin
                bad++;
                $display("FAIL b2b_value[%0d]: pixelw=%0d, need %0d", k, pix_obs[k+3], vals[k]);
            end
        end
        $display("test_back_to_back: wr pattern=%b", wr_obs);
    endtask

    // 7 windows already accepted; stream to 500 then reset with the pipeline full.
    task automatic test_reset_midframe();
        int wr_seen = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 493; k++) begin
            set_flat(8'(k));
            step();
        end
        total++;
        if (wr !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midframe_streaming: wr=%b busy=%b, need 1 and 1", wr, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({wr, busy, done} !== 3'b000 || pixelw !== 8'd0) begin
            bad++;
            $display("FAIL midframe_reset: wr/busy/done=%b pixelw=%0d, need 000 and 0",
                     {wr, busy, done}, pixelw);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (wr) wr_seen++;
        end
        in_valid = 1'b0;
        total++;
        if (wr_seen !== 0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midframe_after: wr pulses=%0d busy=%b done=%b, need 0/0/0",
                     wr_seen, busy, done);
        end
        $display("test_reset_midframe: wr after release=%0d", wr_seen);
    endtask

    task automatic test_full_frame();
        logic [7:0] expq [$];
        int wr_cnt = 0, val_err = 0;
        int first_wr = -1, last_wr = -1, done_cyc = -1;
        logic busy_at_last = 1'b0, busy_at_done = 1'b1;
        logic [7:0] e;
        pulse_start(1'b0);
        for (int c = 0; c < FRAME + 20; c++) begin
            in_valid = (c < FRAME + 10);
            set_flat(8'(c * 7));
            if (c < FRAME) expq.push_back(8'(c * 7));
            step();
            if (wr) begin
                wr_cnt++;
                if (first_wr < 0) first_wr = c + 1;
                last_wr = c + 1;
                busy_at_last = busy;
                e = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                if (pixelw !== e) val_err++;
            end
            if (done && done_cyc < 0) begin
                done_cyc = c + 1;
                busy_at_done = busy;
            end
        end
        in_valid = 1'b0;
        total++;
        if (wr_cnt !== FRAME) begin
            bad++;
            $display("FAIL frame_wr_count: got %0d pulses, need %0d", wr_cnt, FRAME);
        end
        total++;
        if (val_err !== 0) begin
            bad++;
            $display("FAIL frame_values: %0d wrong pixels, need 0", val_err);
        end
        total++;
        if (first_wr !== 3) begin
            bad++;
            $display("FAIL frame_first_wr: first wr at cycle %0d, need 3", first_wr);
        end
        total++;
        if (done_cyc !== last_wr + 1 || done_cyc < 0) begin
            bad++;
            $display("FAIL frame_done_timing: done at %0d, last wr at %0d, need last+1",
                     done_cyc, last_wr);
        end
        total++;
        if (busy_at_last !== 1'b1 || busy_at_done !== 1'b0) begin
            bad++;
            $display("FAIL frame_busy: busy at last wr=%b at done=%b, need 1 and 0",
                     busy_at_last, busy_at_done);
        end
        $display("test_full_frame: wr=%0d first=%0d last=%0d done=%0d",
                 wr_cnt, first_wr, last_wr, done_cyc);
    endtask

    // Starts from DONE in Sobel mode; later mode/start changes must not disturb it.
    task automatic test_sobel();
        logic [71:0] wins [5];
        logic [7:0]  exp_pix [5];
        logic [3:0]  seq;
        logic [7:0]  p3, p4;
        wins[0] = {9{8'd77}};                                    exp_pix[0] = 8'd0;
        wins[1] = {48'd0, 8'd10, 16'd0};                         exp_pix[1] = 8'd20;
        wins[2] = {8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0,
                   8'd255, 8'd255, 8'd0};                        exp_pix[2] = 8'd255;
        wins[3] = {8'd0, 8'd50, 56'd0};                          exp_pix[3] = 8'd100;
        wins[4] = {56'd0, 8'd30, 8'd0};                          exp_pix[4] = 8'd60;
        pulse_start(1'b1);
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL sobel_restart: done=%b busy=%b, need 0 and 1", done, busy);
        end
        mode = 1'b0;
        for (int t = 0; t < 5; t++) begin
            if (t == 3) pulse_start(1'b0);
            for (int k = 0; k < 9; k++) px[k] = wins[t][8*k +: 8];
            send_one(seq, p3, p4);
            total++;
            if (seq !== 4'b0100 || p3 !== exp_pix[t]) begin
                bad++;
                $display("FAIL sobel[%0d]: wr seq=%b pixelw=%0d, need 0100 and %0d",
                         t, seq, p3, exp_pix[t]);
            end
            $display("test_sobel[%0d]: wr seq=%b pixelw=%0d", t, seq, p3);
        end
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL sobel_still_running: busy=%b done=%b, need 1 and 0", busy, done);
        end
    endtask

    initial begin
        set_flat(8'd0);
        test_reset();
        test_idle_ignore();
        test_start_same_cycle();
        test_gauss();
        test_back_to_back();
        test_reset_midframe();
        test_full_frame();
        test_sobel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
